// File: rtl/obi_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : obi_sram_responder
// Description : OBI responder in front of a word-wide SRAM with programmable
//               grant wait states and single-cycle response latency.
// Revision    : 1.0
// ============================================================================
module obi_sram_responder #(
    parameter int MEM_SIZE_BYTE = 32768,
    parameter int WAIT_STATES   = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o
);

    localparam int         c_AW     = $clog2(MEM_SIZE_BYTE);
    localparam int         c_DEPTH  = MEM_SIZE_BYTE / 4;
    localparam logic [2:0] c_WAIT   = 3'(WAIT_STATES);
    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_WAIT = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            rvalid_q;
    logic [31:0]     rdata_q, rdata_d;
    logic [31:0]     mem_q [c_DEPTH];
    logic            w_gnt;
    logic            w_in_range;
    logic [c_AW-3:0] w_idx;
    logic            w_unused;

    assign w_in_range = ((addr_i >> c_AW) == 32'd0);
    assign w_idx      = addr_i[c_AW-1:2];
    assign w_unused   = &{1'b0, addr_i[1:0]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= c_S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A dropped request while waiting abandons the wait entirely.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_S_IDLE: begin
                cnt_d = 3'd0;
                if (req_i && (c_WAIT != 3'd0)) begin
                    state_d = c_S_WAIT;
                    cnt_d   = 3'd1;
                end
            end
            c_S_WAIT: begin
                if (!req_i || (cnt_q == c_WAIT)) begin
                    state_d = c_S_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = c_S_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_comb begin
        w_gnt = 1'b0;
        if (!rst_i) begin
            case (state_q)
                c_S_IDLE: w_gnt = req_i && (c_WAIT == 3'd0);
                c_S_WAIT: w_gnt = req_i && (cnt_q == c_WAIT);
                default:  w_gnt = 1'b0;
            endcase
        end
    end

    assign rdata_d = (!we_i && w_in_range) ? mem_q[w_idx] : 32'd0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            rvalid_q <= w_gnt;
            if (w_gnt) begin
                rdata_q <= rdata_d;
            end
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk_i) begin
        if (w_gnt && we_i && w_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign gnt_o    = w_gnt;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_obi_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_obi_sram_responder
// Description : Self-checking bench; instance 0 has no wait states, 1 has 3.
// Revision    : 1.0
// ============================================================================
module tb_obi_sram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req    [2];
    logic        we     [2];
    logic [3:0]  be     [2];
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic        gnt    [2];
    logic        rvalid [2];
    logic [31:0] rdata  [2];

    int          n_chk = 0;
    int          n_bad = 0;
    logic [31:0] mdl  [2][16];
    logic [31:0] last [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        obi_sram_responder #(
            .MEM_SIZE_BYTE(32768),
            .WAIT_STATES  ((g == 0) ? 0 : 3)
        ) u_dut (
            .clk_i   (clk),
            .rst_i   (rst),
            .req_i   (req[g]),
            .gnt_o   (gnt[g]),
            .addr_i  (addr[g]),
            .we_i    (we[g]),
            .be_i    (be[g]),
            .wdata_i (wdata[g]),
            .rvalid_o(rvalid[g]),
            .rdata_o (rdata[g])
        );
    end

    function automatic int wait_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference memory: returns the response data a granted access must carry.
    function automatic logic [31:0] model_access(input int i, input logic w,
                                                 input logic [31:0] a, input logic [3:0] b,
                                                 input logic [31:0] d);
        logic [31:0] r = 32'd0;
        if (a < 32'd32768) begin
            if (w) begin
                for (int k = 0; k < 4; k++)
                    if (b[k]) mdl[i][a[5:2]][8*k +: 8] = d[8*k +: 8];
            end else begin
                r = mdl[i][a[5:2]];
            end
        end
        return r;
    endfunction

    task automatic rsp_chk(input int i, input bit have, input logic [31:0] e);
        if (have) begin
            chk($sformatf("rvalid_pulse%0d", i), rvalid[i], 1'b1);
            chk($sformatf("rdata%0d", i), rdata[i], e);
            last[i] = e;
        end else begin
            chk($sformatf("rvalid_idle%0d", i), rvalid[i], 1'b0);
            chk($sformatf("rdata_hold%0d", i), rdata[i], last[i]);
        end
    endtask

    task automatic single(input int i, input logic w, input logic [31:0] a,
                          input logic [3:0] b, input logic [31:0] d);
        int          waited = 0;
        logic [31:0] e;
        @(posedge clk); #1;
        req[i] = 1'b1; we[i] = w; addr[i] = a; be[i] = b; wdata[i] = d;
        forever begin
            @(negedge clk);
            if (gnt[i] || waited > 16) break;
            waited++;
        end
        chk($sformatf("gnt_latency%0d", i), waited, wait_of(i));
        e = model_access(i, w, a, b, d);
        @(posedge clk); #1;
        req[i] = 1'b0;
        @(negedge clk);
        rsp_chk(i, 1'b1, e);
    endtask

    task automatic burst(input int i, input int n);
        int          done = 0;
        int          waited = 0;
        bit          active = 0;
        bit          have = 0;
        logic [31:0] e = 32'd0;
        logic        w = 1'b0;
        logic [31:0] a = 32'd0;
        logic [31:0] d = 32'd0;
        logic [3:0]  b = 4'd0;
        while (done < n) begin
            @(posedge clk); #1;
            if (!active) begin
                if ($urandom_range(3) == 0) begin
                    req[i] = 1'b0;
                end else begin
                    w = 1'($urandom_range(1));
                    a = ($urandom_range(7) == 0) ? ($urandom | 32'h0000_8000)
                                                 : {26'd0, 4'($urandom_range(15)), 2'($urandom_range(3))};
                    b = 4'($urandom_range(15));
                    d = $urandom;
                    req[i] = 1'b1; we[i] = w; addr[i] = a; be[i] = b; wdata[i] = d;
                    active = 1; waited = 0;
                end
            end
            @(negedge clk);
            rsp_chk(i, have, e);
            have = 0;
            if (active) begin
                chk($sformatf("gnt_timing%0d", i), gnt[i], (waited == wait_of(i)));
                if (gnt[i]) begin
                    e = model_access(i, w, a, b, d);
                    have = 1; active = 0; done++;
                end else if (waited >= 16) begin
                    active = 0; done++;
                end else begin
                    waited++;
                end
            end else begin
                chk($sformatf("gnt_noreq%0d", i), gnt[i], 1'b0);
            end
        end
        @(posedge clk); #1;
        req[i] = 1'b0;
        @(negedge clk);
        rsp_chk(i, have, e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; be[i] = 4'd0; addr[i] = 32'd0; wdata[i] = 32'd0;
            last[i] = 32'd0;
        end
        #2;
        req[0] = 1'b1; req[1] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_gnt%0d", i), gnt[i], 1'b0);
            chk($sformatf("rst_rvalid%0d", i), rvalid[i], 1'b0);
            chk($sformatf("rst_rdata%0d", i), rdata[i], 32'd0);
        end
        @(posedge clk); #1;
        req[0] = 1'b0; req[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 2; i++)
            for (int wd = 0; wd < 16; wd++)
                single(i, 1'b1, 32'(wd * 4), 4'hF, $urandom | 32'h1);

        for (int i = 0; i < 2; i++) begin
            single(i, 1'b1, 32'h10, 4'hF, 32'hA5A5_1234);
            single(i, 1'b0, 32'h10, 4'h0, 32'h0);
            single(i, 1'b1, 32'h20, 4'hF, 32'h1122_3344);
            single(i, 1'b1, 32'h20, 4'h5, 32'hAABB_CCDD);
            single(i, 1'b0, 32'h20, 4'h0, 32'h0);
            single(i, 1'b1, 32'h8000, 4'hF, 32'hFFFF_FFFF);
            single(i, 1'b0, 32'h8000, 4'h0, 32'h0);
            single(i, 1'b0, 32'h0, 4'h0, 32'h0);
            single(i, 1'b1, 32'h24, 4'h0, 32'hDEAD_0000);
            single(i, 1'b0, 32'h24, 4'h0, 32'h0);
        end

        // Abandoned request on the waiting instance must leave no trace.
        @(posedge clk); #1;
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h20; be[1] = 4'hF; wdata[1] = 32'h5A5A_5A5A;
        @(negedge clk); chk("drop_gnt_c0", gnt[1], 1'b0);
        @(posedge clk); #1;
        @(negedge clk); chk("drop_gnt_c1", gnt[1], 1'b0);
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(negedge clk); chk("drop_gnt_c2", gnt[1], 1'b0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("drop_rvalid", rvalid[1], 1'b0);
        end
        single(1, 1'b0, 32'h20, 4'h0, 32'h0);

        burst(0, 200);
        burst(1, 150);

        // Reset landing on an in-flight read response.
        single(0, 1'b1, 32'h14, 4'hF, 32'hCAFE_F00D);
        single(1, 1'b1, 32'h14, 4'hF, 32'h0BAD_BEEF);
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h14; be[0] = 4'h0;
        @(negedge clk);
        chk("prerst_gnt", gnt[0], 1'b1);
        @(posedge clk); #1;
        req[0] = 1'b0;
        chk("prerst_rvalid", rvalid[0], 1'b1);
        chk("prerst_rdata", rdata[0], mdl[0][5]);
        rst = 1'b1;
        #1;
        chk("rst_async_rvalid", rvalid[0], 1'b0);
        chk("rst_async_rdata", rdata[0], 32'd0);
        req[0] = 1'b1; req[1] = 1'b1;
        @(negedge clk);
        chk("inrst_gnt0", gnt[0], 1'b0);
        chk("inrst_gnt1", gnt[1], 1'b0);
        @(posedge clk); #1;
        req[0] = 1'b0; req[1] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            last[i] = 32'd0;
            rsp_chk(i, 1'b0, 32'd0);
        end
        single(0, 1'b0, 32'h14, 4'h0, 32'h0);
        single(1, 1'b0, 32'h14, 4'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
